// File: rtl/raster_tx.sv
// Raster test-pattern source: streams a latched WxH frame over a valid/ready beat interface.
// Optional RASTER_TX_GAP_EN inserts LFSR-driven idle cycles between beats.
module raster_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_IMG_W = 64,
  parameter int unsigned MAX_IMG_H = 64,
  parameter int unsigned COORD_W   = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_img_w,
  input  logic [COORD_W-1:0] i_img_h,
  input  logic [1:0]         i_mode,
  input  logic [COORD_W-1:0] i_imp_row,
  input  logic [COORD_W-1:0] i_imp_col,
  input  logic [DATA_W-1:0]  i_imp_val,
  input  logic               i_rdy,
  output logic               o_vld,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_eor,
  output logic               o_eof,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e state_q, state_d;

  logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [COORD_W-1:0] imp_row_q, imp_row_d, imp_col_q, imp_col_d;
  logic [1:0]         mode_q, mode_d;
  logic [DATA_W-1:0]  imp_val_q, imp_val_d;

  logic               vld_q, vld_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               eor_q, eor_d;
  logic               eof_q, eof_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [COORD_W-1:0] w_clamp, h_clamp;
  logic [COORD_W-1:0] nrow, ncol;
  logic               start_ok, xfer, last_col, gap;

  function automatic logic [DATA_W-1:0] pixel(
    input logic [1:0]         mode,
    input logic [COORD_W-1:0] row,
    input logic [COORD_W-1:0] col,
    input logic [COORD_W-1:0] irow,
    input logic [COORD_W-1:0] icol,
    input logic [DATA_W-1:0]  val
  );
    logic [DATA_W-1:0] p;
    p = '0;
    case (mode)
      2'd0:    p = val;
      2'd1:    p = (row == irow && col == icol) ? val : '0;
      2'd2:    p = DATA_W'(row) + DATA_W'(col);
      default: p = {DATA_W{row[0] ^ col[0]}};
    endcase
    return p;
  endfunction

`ifdef RASTER_TX_GAP_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign gap = (lfsr_q[3:0] < 4'd3);
`else
  assign gap = 1'b0;
`endif

  assign w_clamp  = (i_img_w > COORD_W'(MAX_IMG_W)) ? COORD_W'(MAX_IMG_W) : i_img_w;
  assign h_clamp  = (i_img_h > COORD_W'(MAX_IMG_H)) ? COORD_W'(MAX_IMG_H) : i_img_h;
  assign start_ok = i_start && (i_img_w != '0) && (i_img_h != '0);
  assign xfer     = vld_q && i_rdy;
  assign last_col = (col_q == w_q - COORD_W'(1));
  assign ncol     = last_col ? '0 : col_q + COORD_W'(1);
  assign nrow     = last_col ? row_q + COORD_W'(1) : row_q;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    row_d     = row_q;
    col_d     = col_q;
    imp_row_d = imp_row_q;
    imp_col_d = imp_col_q;
    mode_d    = mode_q;
    imp_val_d = imp_val_q;
    vld_d     = vld_q;
    data_d    = data_q;
    eor_d     = eor_q;
    eof_d     = eof_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          w_d       = w_clamp;
          h_d       = h_clamp;
          mode_d    = i_mode;
          imp_row_d = i_imp_row;
          imp_col_d = i_imp_col;
          imp_val_d = i_imp_val;
          row_d     = '0;
          col_d     = '0;
          data_d    = pixel(i_mode, '0, '0, i_imp_row, i_imp_col, i_imp_val);
          eor_d     = (w_clamp == COORD_W'(1));
          eof_d     = (w_clamp == COORD_W'(1)) && (h_clamp == COORD_W'(1));
          vld_d     = ~gap;
          busy_d    = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          if (eof_q) begin
            vld_d   = 1'b0;
            eor_d   = 1'b0;
            eof_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            row_d  = nrow;
            col_d  = ncol;
            data_d = pixel(mode_q, nrow, ncol, imp_row_q, imp_col_q, imp_val_q);
            eor_d  = (ncol == w_q - COORD_W'(1));
            eof_d  = (ncol == w_q - COORD_W'(1)) && (nrow == h_q - COORD_W'(1));
            vld_d  = ~gap;
          end
        end else if (!vld_q) begin
          // A gap lasts exactly one cycle; the staged beat is presented next.
          vld_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      w_q       <= '0;
      h_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      imp_row_q <= '0;
      imp_col_q <= '0;
      mode_q    <= '0;
      imp_val_q <= '0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      eor_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      row_q     <= row_d;
      col_q     <= col_d;
      imp_row_q <= imp_row_d;
      imp_col_q <= imp_col_d;
      mode_q    <= mode_d;
      imp_val_q <= imp_val_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      eor_q     <= eor_d;
      eof_q     <= eof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_vld  = vld_q;
  assign o_data = data_q;
  assign o_eor  = eor_q;
  assign o_eof  = eof_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_raster_tx.sv
// Self-checking bench for raster_tx: table of frames checked through a beat scoreboard,
// plus hand-written sequences for ignored starts and mid-frame reset.
module tb_raster_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [6:0] img_w = '0, img_h = '0, imp_row = '0, imp_col = '0;
  logic [1:0] mode = '0;
  logic [7:0] imp_val = '0;
  logic       rdy = 1'b0;
  logic       vld, eor, eof, busy, done;
  logic [7:0] data;

  always #5 clk = ~clk;

  raster_tx #(
    .DATA_W   (8),
    .MAX_IMG_W(64),
    .MAX_IMG_H(64),
    .COORD_W  (7)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_img_w  (img_w),
    .i_img_h  (img_h),
    .i_mode   (mode),
    .i_imp_row(imp_row),
    .i_imp_col(imp_col),
    .i_imp_val(imp_val),
    .i_rdy    (rdy),
    .o_vld    (vld),
    .o_data   (data),
    .o_eor    (eor),
    .o_eof    (eof),
    .o_busy   (busy),
    .o_done   (done)
  );

  typedef struct {
    int w, h, mode, irow, icol, ival, rdy_pct;
    bit hold_start;
    int exp_beats, exp_eor, exp_nz, exp_first_nz;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       eor;
    logic       eof;
  } beat_t;

  beat_t sb[$];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pix(int m, int r, int c, int ir, int ic, int iv);
    case (m)
      0:       return iv;
      1:       return (r == ir && c == ic) ? iv : 0;
      2:       return (r + c) % 256;
      default: return ((r % 2) != (c % 2)) ? 255 : 0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s vld", tag), vld, 0);
    chk($sformatf("%s data", tag), data, 0);
    chk($sformatf("%s eor", tag), eor, 0);
    chk($sformatf("%s eof", tag), eof, 0);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s done", tag), done, 0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int    beats = 0, eors = 0, eofs = 0, nz = 0, first_nz = -1, cycles = 0;
    int    we, he;
    bit    fin = 0, stalled = 0;
    beat_t held, exp;
    we = (v.w > 64) ? 64 : v.w;
    he = (v.h > 64) ? 64 : v.h;
    for (int r = 0; r < he; r++) begin
      for (int c = 0; c < we; c++) begin
        exp.data = 8'(model_pix(v.mode, r, c, v.irow, v.icol, v.ival));
        exp.eor  = (c == we - 1);
        exp.eof  = (c == we - 1) && (r == he - 1);
        sb.push_back(exp);
      end
    end
    img_w   = 7'(v.w);
    img_h   = 7'(v.h);
    mode    = 2'(v.mode);
    imp_row = 7'(v.irow);
    imp_col = 7'(v.icol);
    imp_val = 8'(v.ival);
    rdy     = 1'b0;
    start   = 1'b1;
    tick();
    if (!v.hold_start) start = 1'b0;
    // Disturb every latched input; the frame must not notice.
    img_w   = 7'd2;
    img_h   = 7'd2;
    mode    = mode + 2'd1;
    imp_val = ~imp_val;
    imp_row = '0;
    imp_col = '0;
`ifndef RASTER_TX_GAP_EN
    chk($sformatf("v%0d first vld", idx), vld, 1);
`endif
    while (!fin && cycles < 20000) begin
      rdy = ($urandom_range(0, 99) < v.rdy_pct);
      if (stalled) begin
        chk($sformatf("v%0d stall vld", idx), vld, 1);
        chk($sformatf("v%0d stall beat", idx), {data, eor, eof}, held);
      end
      chk($sformatf("v%0d busy", idx), busy, 1);
      stalled = vld && !rdy;
      held    = {data, eor, eof};
      if (vld && rdy) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d extra beat", idx), beats, -1);
        end else begin
          exp = sb.pop_front();
          chk($sformatf("v%0d b%0d data", idx, beats), data, exp.data);
          chk($sformatf("v%0d b%0d eor", idx, beats), eor, exp.eor);
          chk($sformatf("v%0d b%0d eof", idx, beats), eof, exp.eof);
        end
        if (data != 0 && first_nz < 0) first_nz = beats;
        nz    += (data != 0) ? 1 : 0;
        eors  += eor ? 1 : 0;
        eofs  += eof ? 1 : 0;
        beats++;
        if (eof) fin = 1;
      end
      tick();
      cycles++;
      if (!fin) chk($sformatf("v%0d early done", idx), done, 0);
    end
    chk($sformatf("v%0d timeout", idx), fin, 1);
    start = 1'b0;
    rdy   = 1'b0;
    chk($sformatf("v%0d done", idx), done, 1);
    chk($sformatf("v%0d vld after eof", idx), vld, 0);
    chk($sformatf("v%0d busy after eof", idx), busy, 0);
    chk($sformatf("v%0d beats", idx), beats, v.exp_beats);
    chk($sformatf("v%0d eor count", idx), eors, v.exp_eor);
    chk($sformatf("v%0d eof count", idx), eofs, 1);
    chk($sformatf("v%0d nonzero", idx), nz, v.exp_nz);
    chk($sformatf("v%0d first nonzero", idx), first_nz, v.exp_first_nz);
`ifndef RASTER_TX_GAP_EN
    if (v.rdy_pct == 100) chk($sformatf("v%0d cycles", idx), cycles, beats);
`else
    if (v.rdy_pct == 100 && beats >= 100) chk($sformatf("v%0d gaps", idx), cycles > beats, 1);
`endif
    tick();
    chk($sformatf("v%0d done width", idx), done, 0);
    chk($sformatf("v%0d idle busy", idx), busy, 0);
    chk($sformatf("v%0d idle vld", idx), vld, 0);
    chk($sformatf("v%0d sb drained", idx), sb.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    //         w   h  mode irow icol ival  rdy hold beats eor  nz  first
    vecs[0] = '{4,   3,  2,  0,   0,   0,   100, 0,  12,   3,  11,  1};
    vecs[1] = '{20,  20, 1,  10,  10,  255, 100, 0,  400,  20, 1,   210};
    vecs[2] = '{20,  20, 3,  0,   0,   0,   70,  0,  400,  20, 200, 1};
    vecs[3] = '{5,   2,  0,  0,   0,   90,  50,  1,  10,   2,  10,  0};
    vecs[4] = '{4,   4,  1,  9,   1,   119, 100, 0,  16,   4,  0,   -1};
    vecs[5] = '{70,  1,  0,  0,   0,   17,  100, 0,  64,   1,  64,  0};
    vecs[6] = '{3,   100, 2, 0,   0,   0,   80,  1,  192,  64, 191, 1};
    vecs[7] = '{1,   1,  3,  0,   0,   0,   100, 0,  1,    1,  0,   -1};

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post reset idle");

    // Zero-sized starts are ignored.
    img_w = 7'd0; img_h = 7'd5; start = 1'b1;
    tick();
    img_w = 7'd5; img_h = 7'd0;
    tick();
    start = 1'b0;
    chk("zero size busy", busy, 0);
    chk("zero size vld", vld, 0);
    tick();
    chk("zero size done", done, 0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Reset after five transfers abandons the frame.
    img_w = 7'd20; img_h = 7'd20; mode = 2'd0; imp_val = 8'h33; rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid-frame reset");
    tick();
    rst_n = 1'b1;
    rdy   = 1'b0;
    tick();
    check_all_zero("after mid reset");
    run_frame(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
